dmem_ctrl: RTL

DMEM_CTRL -- requirements
Module: dmem_ctrl

---
 rtl/types_pkg.sv | 14 +
 rtl/dmem_align.sv | 62 ++++++
 rtl/dmem_ctrl.sv | 134 +++++++++++++
 3 files changed

// File: rtl/types_pkg.sv
// Shared datapath types for the load/store and fetch paths.
// Sizes follow the RV32I load/store funct3 encodings.
package types_pkg;

    typedef logic [31:0] word_t;
    typedef logic [2:0]  mem_size_t;

    localparam mem_size_t F3_B  = 3'd0;
    localparam mem_size_t F3_H  = 3'd1;
    localparam mem_size_t F3_W  = 3'd2;
    localparam mem_size_t F3_BU = 3'd4;
    localparam mem_size_t F3_HU = 3'd5;

endpackage

// File: rtl/dmem_align.sv
// Byte-lane enables, store lane replication, load extraction and
// size/alignment legality for one 32-bit memory word.
module dmem_align
    import types_pkg::*;
(
    input  mem_size_t   size,
    input  logic        write,
    input  logic [1:0]  lo,
    input  word_t       wdata,
    input  word_t       rword,
    output logic [3:0]  be,
    output word_t       wlane,
    output word_t       rext,
    output logic        err
);

    word_t       bsh;
    word_t       hsh;
    logic [7:0]  b;
    logic [15:0] h;

    assign bsh = rword >> {lo, 3'b000};
    assign hsh = rword >> {lo[1], 4'b0000};
    assign b   = bsh[7:0];
    assign h   = hsh[15:0];

    always_comb begin
        be    = 4'b0000;
        wlane = '0;
        rext  = '0;
        err   = 1'b0;
        unique case (1'b1)
            (size == F3_B): begin
                be    = 4'b0001 << lo;
                wlane = {4{wdata[7:0]}};
                rext  = {{24{b[7]}}, b};
            end
            (size == F3_H): begin
                err   = lo[0];
                be    = 4'b0011 << {lo[1], 1'b0};
                wlane = {2{wdata[15:0]}};
                rext  = {{16{h[15]}}, h};
            end
            (size == F3_W): begin
                err   = (lo != 2'b00);
                be    = 4'b1111;
                wlane = wdata;
                rext  = rword;
            end
            (size == F3_BU): begin
                err   = write;
                rext  = {24'h0, b};
            end
            (size == F3_HU): begin
                err   = write | lo[0];
                rext  = {16'h0, h};
            end
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Single-port data memory controller with fixed access latency and
// a valid/ready request/response handshake.
module dmem_ctrl
    import types_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      req_valid,
    output logic      req_ready,
    input  logic      req_write,
    input  mem_size_t req_size,
    input  word_t     req_addr,
    input  word_t     req_wdata,
    output logic      rsp_valid,
    input  logic      rsp_ready,
    output word_t     rsp_rdata,
    output logic      rsp_err
);

    localparam int IW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t    state;
    state_t    state_nx;
    logic [3:0] cnt;
    logic      r_write;
    mem_size_t r_size;
    word_t     r_addr;
    word_t     r_wdata;

    word_t     mem [DEPTH_WORDS];

    logic        accept;
    logic        commit;
    logic        fmt_err;
    logic        range_err;
    logic        err;
    logic [3:0]  be;
    word_t       wlane;
    word_t       rext;
    word_t       rword;
    logic [IW-1:0] idx;

    assign idx       = r_addr[IW+1:2];
    assign range_err = |r_addr[31:IW+2];
    assign err       = fmt_err | range_err;
    assign rword     = mem[idx];

    dmem_align u_align (
        .size  (r_size),
        .write (r_write),
        .lo    (r_addr[1:0]),
        .wdata (r_wdata),
        .rword (rword),
        .be    (be),
        .wlane (wlane),
        .rext  (rext),
        .err   (fmt_err)
    );

    // Held low during reset even though the state already reads IDLE
    assign req_ready = (state == S_IDLE) & reset;
    assign rsp_valid = (state == S_RESP);

    always_comb begin
        state_nx = state;
        accept   = 1'b0;
        commit   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (req_valid && req_ready) begin
                    accept   = 1'b1;
                    state_nx = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt == 4'd0) begin
                    commit   = 1'b1;
                    state_nx = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cnt       <= 4'd0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            r_write   <= 1'b0;
            r_size    <= F3_B;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                r_write <= req_write;
                r_size  <= req_size;
                r_addr  <= req_addr;
                r_wdata <= req_wdata;
                cnt     <= 4'(LATENCY - 1);
            end else if (state == S_WAIT && cnt != 4'd0) begin
                cnt <= cnt - 4'd1;
            end
            if (commit) begin
                rsp_err   <= err;
                rsp_rdata <= (err | r_write) ? '0 : rext;
            end
        end
    end

    // Array is not reset; commit can only fire out of WAIT
    always_ff @(posedge clk) begin
        if (commit && r_write && !err) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[idx][8*i +: 8] <= wlane[8*i +: 8];
            end
        end
    end

endmodule
